// File: rtl/hazard_pkg.sv
// Shared types for the second-generation hazard unit: forwarding selects,
// hazard FSM states and the forwarding priority helper.
package hazard_pkg;

    // Execute-stage operand source select
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // Sequential wait states of the hazard unit
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    // M result is younger than W, so it wins when both match
    function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
        fwd_sel_t sel;
        if (hit_m)
            sel = FWD_M;
        else if (hit_w)
            sel = FWD_W;
        else
            sel = FWD_RF;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_gen2_fwd_match.sv
// Per-operand comparator: forwarding select for the E-stage source and
// load-use match for the D-stage source of the same operand slot.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 4
) (
    input  logic [REG_ADDR_W-1:0] ra_e,
    input  logic [REG_ADDR_W-1:0] ra_d,
    input  logic [REG_ADDR_W-1:0] wa3_e,
    input  logic [REG_ADDR_W-1:0] wa3_m,
    input  logic [REG_ADDR_W-1:0] wa3_w,
    input  logic                  regwrite_m,
    input  logic                  regwrite_w,
    output fwd_sel_t              sel,
    output logic                  ld_hit
);

    logic hit_m;
    logic hit_w;

    // Address compares against in-flight destinations
    always_comb begin
        hit_m  = regwrite_m && (ra_e == wa3_m);
        hit_w  = regwrite_w && (ra_e == wa3_w);
        sel    = fwd_pick(hit_m, hit_w);
        ld_hit = (ra_d == wa3_e);
    end

endmodule

// File: rtl/hazard_ctrl_gen2.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use stall,
// PC/branch flushes, plus sequencing for a multi-cycle execute unit and a
// variable-latency data memory with a sticky timeout flag.
module hazard_ctrl_gen2
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 4,
    parameter int N_SRC       = 2,
    parameter int MUL_LAT     = 3,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                        CLK_50,
    input  logic                        reset,
    input  logic [N_SRC*REG_ADDR_W-1:0] ra_d,
    input  logic [N_SRC*REG_ADDR_W-1:0] ra_e,
    input  logic [REG_ADDR_W-1:0]       wa3_e,
    input  logic [REG_ADDR_W-1:0]       wa3_m,
    input  logic [REG_ADDR_W-1:0]       wa3_w,
    input  logic                        regwrite_m,
    input  logic                        regwrite_w,
    input  logic                        memtoreg_e,
    input  logic                        pcsrc_d,
    input  logic                        pcsrc_e,
    input  logic                        pcsrc_m,
    input  logic                        pcsrc_w,
    input  logic                        branchtaken_e,
    input  logic                        mul_start_e,
    input  logic                        mem_req_m,
    input  logic                        mem_ack,
    output logic [2*N_SRC-1:0]          forward_e,
    output logic                        stall_f,
    output logic                        stall_d,
    output logic                        stall_e,
    output logic                        stall_m,
    output logic                        flush_d,
    output logic                        flush_e,
    output logic                        flush_m,
    output logic                        flush_w,
    output logic                        mem_err,
    output logic                        busy
);

    localparam int MUL_W = $clog2(MUL_LAT + 1);
    localparam int MEM_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [MUL_W-1:0] MUL_LOAD = MUL_W'(MUL_LAT - 1);
    localparam logic [MUL_W-1:0] MUL_ONE  = MUL_W'(1);
    localparam logic [MEM_W-1:0] MEM_MAX  = MEM_W'(MEM_TIMEOUT);
    localparam logic [MEM_W-1:0] MEM_ONE  = MEM_W'(1);
    localparam logic             MUL_MULTI = (MUL_LAT > 1);

    hz_state_t             state, state_nxt;
    logic [MUL_W-1:0]      mul_cnt, mul_cnt_nxt;
    logic [MEM_W-1:0]      mem_cnt, mem_cnt_nxt;
    logic                  mem_err_nxt;

    fwd_sel_t              fwd_sel [N_SRC];
    logic [N_SRC-1:0]      ld_hit;
    logic [2*N_SRC-1:0]    fwd_raw;

    logic ldr_stall;
    logic pc_pend;
    logic mem_start;
    logic mem_done;
    logic mul_go;
    logic mem_hold;
    logic mul_hold;

    // One comparator per operand slot
    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        fwd_match #(
            .REG_ADDR_W (REG_ADDR_W)
        ) u_match (
            .ra_e       (ra_e[i*REG_ADDR_W +: REG_ADDR_W]),
            .ra_d       (ra_d[i*REG_ADDR_W +: REG_ADDR_W]),
            .wa3_e      (wa3_e),
            .wa3_m      (wa3_m),
            .wa3_w      (wa3_w),
            .regwrite_m (regwrite_m),
            .regwrite_w (regwrite_w),
            .sel        (fwd_sel[i]),
            .ld_hit     (ld_hit[i])
        );
        assign fwd_raw[2*i +: 2] = fwd_sel[i];
    end

    // Request decode; an ack with no request in M is meaningless and dropped
    always_comb begin
        ldr_stall = memtoreg_e && (|ld_hit);
        pc_pend   = pcsrc_d | pcsrc_e | pcsrc_m;
        mem_start = mem_req_m && !mem_ack;
        mem_done  = mem_req_m && mem_ack;
        mul_go    = MUL_MULTI && mul_start_e;
        // Holds act in the cycle the request is seen, not a cycle later
        mem_hold  = ((state == MEM_WAIT) && !mem_done) || ((state == RUN) && mem_start);
        mul_hold  = (state == MUL_WAIT) || ((state == RUN) && mul_go);
    end

    // State, counters and sticky timeout flag
    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            mul_cnt <= '0;
            mem_cnt <= '0;
            mem_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            mul_cnt <= mul_cnt_nxt;
            mem_cnt <= mem_cnt_nxt;
            mem_err <= mem_err_nxt;
        end
    end

    // Next state: memory wait preempts the multiply, which resumes with its
    // remaining count once the access completes
    always_comb begin
        state_nxt   = state;
        mul_cnt_nxt = mul_cnt;
        mem_cnt_nxt = mem_cnt;
        mem_err_nxt = mem_err;
        case (state)
            RUN: begin
                if (mul_go)
                    mul_cnt_nxt = MUL_LOAD;
                if (mem_start) begin
                    state_nxt   = MEM_WAIT;
                    mem_cnt_nxt = MEM_ONE;
                end else if (mul_go) begin
                    state_nxt   = MUL_WAIT;
                end
            end
            MUL_WAIT: begin
                if (mem_start) begin
                    state_nxt   = MEM_WAIT;
                    mem_cnt_nxt = MEM_ONE;
                end else if (mul_cnt <= MUL_ONE) begin
                    mul_cnt_nxt = '0;
                    state_nxt   = RUN;
                end else begin
                    mul_cnt_nxt = mul_cnt - MUL_ONE;
                end
            end
            MEM_WAIT: begin
                if (mem_done) begin
                    mem_cnt_nxt = '0;
                    state_nxt   = (mul_cnt != '0) ? MUL_WAIT : RUN;
                end else if (mem_cnt < MEM_MAX) begin
                    mem_cnt_nxt = mem_cnt + MEM_ONE;
                    if (mem_cnt_nxt == MEM_MAX)
                        mem_err_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Stage controls: reset bubbles everything, then memory wait, then
    // multiply wait, then the single-cycle hazard logic
    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_m   = 1'b0;
        flush_w   = 1'b0;
        forward_e = fwd_raw;
        busy      = (state != RUN);
        if (!reset) begin
            flush_d   = 1'b1;
            flush_e   = 1'b1;
            flush_m   = 1'b1;
            flush_w   = 1'b1;
            forward_e = '0;
        end else if (mem_hold) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (mul_hold) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else begin
            stall_d = ldr_stall;
            stall_f = ldr_stall | pc_pend;
            flush_e = ldr_stall | branchtaken_e;
            flush_d = pc_pend | pcsrc_w | branchtaken_e;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_gen2.sv
// Directed bench for hazard_ctrl_gen2 with an expectation queue.
module tb_hazard_ctrl_gen2;

    localparam int AW = 4;
    localparam int NS = 2;
    localparam int ML = 3;
    localparam int MT = 8;

    logic           CLK_50 = 1'b0;
    logic           reset  = 1'b0;
    logic [NS*AW-1:0] ra_d, ra_e;
    logic [AW-1:0]  wa3_e, wa3_m, wa3_w;
    logic           regwrite_m, regwrite_w, memtoreg_e;
    logic           pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w;
    logic           branchtaken_e, mul_start_e, mem_req_m, mem_ack;
    logic [2*NS-1:0] forward_e;
    logic           stall_f, stall_d, stall_e, stall_m;
    logic           flush_d, flush_e, flush_m, flush_w;
    logic           mem_err, busy;

    hazard_ctrl_gen2 #(
        .REG_ADDR_W (AW),
        .N_SRC      (NS),
        .MUL_LAT    (ML),
        .MEM_TIMEOUT(MT)
    ) dut (
        .CLK_50        (CLK_50),
        .reset         (reset),
        .ra_d          (ra_d),
        .ra_e          (ra_e),
        .wa3_e         (wa3_e),
        .wa3_m         (wa3_m),
        .wa3_w         (wa3_w),
        .regwrite_m    (regwrite_m),
        .regwrite_w    (regwrite_w),
        .memtoreg_e    (memtoreg_e),
        .pcsrc_d       (pcsrc_d),
        .pcsrc_e       (pcsrc_e),
        .pcsrc_m       (pcsrc_m),
        .pcsrc_w       (pcsrc_w),
        .branchtaken_e (branchtaken_e),
        .mul_start_e   (mul_start_e),
        .mem_req_m     (mem_req_m),
        .mem_ack       (mem_ack),
        .forward_e     (forward_e),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .stall_e       (stall_e),
        .stall_m       (stall_m),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .flush_m       (flush_m),
        .flush_w       (flush_w),
        .mem_err       (mem_err),
        .busy          (busy)
    );

    always #5 CLK_50 = ~CLK_50;

    // {forward_e, stall f/d/e/m, flush d/e/m/w, mem_err, busy}
    typedef struct packed {
        logic [3:0] fwd;
        logic [3:0] stl;
        logic [3:0] fls;
        logic       err;
        logic       bsy;
    } obs_t;

    obs_t  obs;
    obs_t  exp_q [$];
    string tag_q [$];
    int    n_cmp = 0;
    int    n_mis = 0;

    assign obs = {forward_e, stall_f, stall_d, stall_e, stall_m,
                  flush_d, flush_e, flush_m, flush_w, mem_err, busy};

    task automatic idle();
        ra_d = '0; ra_e = '0; wa3_e = '0; wa3_m = '0; wa3_w = '0;
        regwrite_m = 0; regwrite_w = 0; memtoreg_e = 0;
        pcsrc_d = 0; pcsrc_e = 0; pcsrc_m = 0; pcsrc_w = 0;
        branchtaken_e = 0; mul_start_e = 0; mem_req_m = 0; mem_ack = 0;
    endtask

    task automatic expect_now(input string tag, input logic [3:0] fwd,
                              input logic [3:0] stl, input logic [3:0] fls,
                              input logic err, input logic bsy);
        obs_t e;
        e = '{fwd: fwd, stl: stl, fls: fls, err: err, bsy: bsy};
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Compare mid-cycle, then move to just after the next rising edge
    task automatic sample();
        obs_t  e;
        string t;
        @(negedge CLK_50);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert (obs === e) else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", t, obs, e);
        end
        @(posedge CLK_50);
        #1;
    endtask

    initial begin
        idle();
        // Forwarding candidates present during reset must be masked
        ra_e = {4'd0, 4'd3}; wa3_m = 4'd3; regwrite_m = 1;
        @(posedge CLK_50); #1;
        expect_now("reset", 4'b0000, 4'b0000, 4'b1111, 0, 0); sample();
        reset = 1'b1;

        // Forwarding: M beats W, then W alone, then mixed per source
        ra_e = {4'd0, 4'd3}; wa3_m = 4'd3; regwrite_m = 1; wa3_w = 4'd3; regwrite_w = 1;
        expect_now("fwd_m_pri", 4'b0010, 4'b0000, 4'b0000, 0, 0); sample();
        regwrite_m = 0;
        expect_now("fwd_w", 4'b0001, 4'b0000, 4'b0000, 0, 0); sample();
        regwrite_m = 1; ra_e = {4'd7, 4'd3}; wa3_w = 4'd7;
        expect_now("fwd_mixed", 4'b0110, 4'b0000, 4'b0000, 0, 0); sample();

        // Load-use on source 1
        idle();
        memtoreg_e = 1; wa3_e = 4'd5; ra_d = {4'd5, 4'd0};
        expect_now("ldr_stall", 4'b0000, 4'b1100, 4'b0100, 0, 0); sample();
        memtoreg_e = 0;
        expect_now("ldr_clear", 4'b0000, 4'b0000, 4'b0000, 0, 0); sample();

        // PC-write pending and writeback PC flush
        idle(); pcsrc_e = 1;
        expect_now("pc_pend", 4'b0000, 4'b1000, 4'b1000, 0, 0); sample();
        idle(); pcsrc_w = 1;
        expect_now("pcsrc_w", 4'b0000, 4'b0000, 4'b1000, 0, 0); sample();

        // Branch with load-use, then the same with a memory wait on top
        idle(); branchtaken_e = 1; memtoreg_e = 1; wa3_e = 4'd5; ra_d = {4'd5, 4'd0};
        expect_now("br_ldr", 4'b0000, 4'b1100, 4'b1100, 0, 0); sample();
        mem_req_m = 1; mem_ack = 0;
        expect_now("br_ldr_mem", 4'b0000, 4'b1111, 4'b0001, 0, 0); sample();

        // Memory wait: four stalled cycles, released in the ack cycle
        idle(); mem_req_m = 1;
        for (int k = 2; k <= 4; k++) begin
            expect_now("mem_wait", 4'b0000, 4'b1111, 4'b0001, 0, 1); sample();
        end
        mem_ack = 1;
        expect_now("mem_ack", 4'b0000, 4'b0000, 4'b0000, 0, 1); sample();
        idle();
        expect_now("mem_done", 4'b0000, 4'b0000, 4'b0000, 0, 0); sample();

        // Multiply: three held cycles, busy for the last two
        mul_start_e = 1;
        expect_now("mul_start", 4'b0000, 4'b1110, 4'b0010, 0, 0); sample();
        mul_start_e = 0;
        expect_now("mul_w1", 4'b0000, 4'b1110, 4'b0010, 0, 1); sample();
        expect_now("mul_w2", 4'b0000, 4'b1110, 4'b0010, 0, 1); sample();
        expect_now("mul_done", 4'b0000, 4'b0000, 4'b0000, 0, 0); sample();

        // Simultaneous start: memory first, multiply resumes afterwards
        mul_start_e = 1; mem_req_m = 1;
        expect_now("both_start", 4'b0000, 4'b1111, 4'b0001, 0, 0); sample();
        mul_start_e = 0;
        expect_now("both_mem", 4'b0000, 4'b1111, 4'b0001, 0, 1); sample();
        mem_ack = 1;
        expect_now("both_ack", 4'b0000, 4'b0000, 4'b0000, 0, 1); sample();
        idle();
        expect_now("resume_m1", 4'b0000, 4'b1110, 4'b0010, 0, 1); sample();
        expect_now("resume_m2", 4'b0000, 4'b1110, 4'b0010, 0, 1); sample();
        expect_now("resume_end", 4'b0000, 4'b0000, 4'b0000, 0, 0); sample();

        // Timeout: flag rises once eight wait cycles have elapsed
        mem_req_m = 1;
        expect_now("to_w1", 4'b0000, 4'b1111, 4'b0001, 0, 0); sample();
        for (int k = 2; k <= MT; k++) begin
            expect_now("to_wait", 4'b0000, 4'b1111, 4'b0001, 0, 1); sample();
        end
        expect_now("to_err", 4'b0000, 4'b1111, 4'b0001, 1, 1); sample();
        expect_now("to_sat", 4'b0000, 4'b1111, 4'b0001, 1, 1); sample();
        mem_ack = 1;
        expect_now("to_ack", 4'b0000, 4'b0000, 4'b0000, 1, 1); sample();
        idle();
        expect_now("err_sticky", 4'b0000, 4'b0000, 4'b0000, 1, 0); sample();

        // Reset in the middle of a memory wait
        mem_req_m = 1;
        expect_now("pre_rst_w", 4'b0000, 4'b1111, 4'b0001, 1, 0); sample();
        reset = 1'b0;
        expect_now("rst_mid", 4'b0000, 4'b0000, 4'b1111, 0, 0); sample();
        reset = 1'b1; idle();
        expect_now("post_rst", 4'b0000, 4'b0000, 4'b0000, 0, 0); sample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_gen2.md
Name: hazard_ctrl_gen2

Overview:
Second-generation hazard unit for the 5-stage ARM pipeline (F/D/E/M/W). It generates forwarding selects for N_SRC execute-stage operands, detects load-use hazards, and handles PC-write and branch flushes. It adds sequential control for a multi-cycle execute unit (MUL_LAT cycles) and for a variable-latency data memory handshake with a timeout. It sits beside the datapath and control path in the pipeline top, replacing the single-cycle combinational hazard unit.

Parameters:
REG_ADDR_W, 4, register-address width.
N_SRC, 2, number of execute-stage source operands needing forwarding.
MUL_LAT, 3, execute latency of a multi-cycle op in cycles (minimum 1).
MEM_TIMEOUT, 64, wait cycles before mem_err is raised (minimum 2).

Ports:
CLK_50  in  1  pipeline clock.
reset  in  1  asynchronous, active-low reset (0 = reset).
ra_d  in  N_SRC*REG_ADDR_W  decode-stage source register addresses (src i at slice i).
ra_e  in  N_SRC*REG_ADDR_W  execute-stage source register addresses.
wa3_e / wa3_m / wa3_w  in  REG_ADDR_W each  destination register per stage.
regwrite_m, regwrite_w  in  1  write enables in M and W.
memtoreg_e  in  1  load in E.
pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w  in  1  PC-write pending per stage.
branchtaken_e  in  1  branch resolved taken in E.
mul_start_e  in  1  single-cycle pulse: a multi-cycle op entered E.
mem_req_m  in  1  data-memory access active in M.
mem_ack  in  1  memory completes the access this cycle.
forward_e  out  2*N_SRC  per-source select: 00 = RF, 10 = ALUResultM, 01 = ResultW.
stall_f, stall_d, stall_e, stall_m  out  1  stage hold enables.
flush_d, flush_e, flush_m, flush_w  out  1  stage bubble inserts.
mem_err  out  1  sticky memory-timeout flag.
busy  out  1  FSM not in RUN.

Behaviour:
- Reset (reset=0, async): FSM=RUN, mul_cnt=0, mem_cnt=0, mem_err=0. Outputs: all stall_* = 0, all flush_* = 1, forward_e = 0, busy = 0.
- Forwarding (combinational, every cycle, including during stalls), per src i:
  - 10 if regwrite_m and ra_e[i]==wa3_m;
  - else 01 if regwrite_w and ra_e[i]==wa3_w;
  - else 00.
  - M has priority over W.
- ldr_stall = memtoreg_e and (any ra_d[i]==wa3_e).
- pc_pend = pcsrc_d | pcsrc_e | pcsrc_m.
- FSM states:
  - RUN: no multi-cycle wait.
  - MUL_WAIT: mul_cnt > 0.
  - MEM_WAIT: memory outstanding.
- RUN -> MEM_WAIT when mem_req_m and !mem_ack; mem_cnt <= 1.
- RUN -> MUL_WAIT when mul_start_e and MUL_LAT > 1 and no memory wait; mul_cnt <= MUL_LAT-1.
- If both start in the same cycle, MEM_WAIT wins. mul_cnt still loads and counts down only while not in MEM_WAIT. On mem_ack, go to MUL_WAIT if mul_cnt > 0, else RUN.
- MUL_WAIT: mul_cnt decrements each cycle. At 1 -> 0, return to RUN in that cycle's clock edge. A mem wait arising here preempts to MEM_WAIT (mul_cnt frozen).
- MEM_WAIT: mem_cnt increments, saturating. When mem_cnt reaches MEM_TIMEOUT, set mem_err=1 (sticky until reset); FSM stays in MEM_WAIT. mem_ack returns as above; mem_cnt <= 0.
- Output priority (highest first):
  1. Memory wait (MEM_WAIT, or RUN with mem_req_m & !mem_ack): stall_f/d/e/m=1, flush_w=1, all other flushes 0.
  2. Mul wait (MUL_WAIT, or RUN with mul_start_e & MUL_LAT > 1): stall_f/d/e=1, flush_m=1.
  3. Base logic:
     - stall_d = ldr_stall;
     - stall_f = ldr_stall | pc_pend;
     - flush_e = ldr_stall | branchtaken_e;
     - flush_d = pc_pend | pcsrc_w | branchtaken_e;
     - stall_e = stall_m = flush_m = flush_w = 0.
- Level 1 and 2 conditions are evaluated combinationally, so the stall is asserted in the same cycle the request is seen (zero-latency).
- busy = (FSM != RUN).
- Reset mid-wait aborts immediately: counters cleared, FSM to RUN.
- mem_ack without mem_req_m is ignored.
- mul_start_e while in MUL_WAIT is ignored (E is stalled).

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10);
  - hz_state_t enum (RUN, MUL_WAIT, MEM_WAIT).
- One sub-module, fwd_match: per-source comparator instantiated N_SRC times via generate. FSM and counters stay in the top.

Test Plan:
- ra_e[0]=3, wa3_m=3, regwrite_m=1, wa3_w=3, regwrite_w=1 -> forward_e[1:0]=10. Drop regwrite_m -> 01.
- memtoreg_e=1, wa3_e=5, ra_d[1]=5 -> stall_f=1, stall_d=1, flush_e=1 for one cycle. Next cycle memtoreg_e=0 -> all 0.
- MUL_LAT=3, mul_start_e pulse -> stall_f/d/e=1 and flush_m=1 for exactly 3 cycles (start cycle + 2), busy=1 for 2; then RUN.
- mem_req_m=1, mem_ack low 4 cycles then high -> stall_f/d/e/m=1 and flush_w=1 for 4 cycles, all released in the ack cycle; mem_err=0.
- mem_req_m=1, no ack, MEM_TIMEOUT=8 -> mem_err rises after 8 wait cycles and stays 1 after ack. Assert reset=0 -> mem_err=0, all flushes 1.
- branchtaken_e=1 with ldr_stall=1 -> flush_d=1, flush_e=1, stall_f=1. Same cycle with mem wait -> only stall_f/d/e/m and flush_w asserted.
